// File: rtl/vrf_banked_collector.sv
// Banked vector register file with a multi-cycle operand collector on the read
// side and per-bank write queues that absorb write-back bank conflicts.
module vrf_banked_collector #(
    parameter int NBANK    = 4,
    parameter int DEPTH    = 16,
    parameter int VLEN     = 128,
    parameter int RPORT    = 4,
    parameter int BANK_RD  = 2,
    parameter int WPORT    = 2,
    parameter int WQ_DEPTH = 4,
    parameter int TAG_W    = 6,
    localparam int NREG    = NBANK * DEPTH,
    localparam int AW      = $clog2(NREG),
    localparam int BW      = $clog2(NBANK)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [RPORT-1:0]      req_op_vld,
    input  logic [RPORT*AW-1:0]   req_op_addr,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [RPORT-1:0]      rsp_op_vld,
    output logic [RPORT*VLEN-1:0] rsp_data,
    input  logic [WPORT-1:0]      wr_vld,
    output logic [WPORT-1:0]      wr_rdy,
    input  logic [WPORT*AW-1:0]   wr_addr,
    input  logic [WPORT*VLEN-1:0] wr_data,
    output logic                  wq_empty
);
    localparam int RW = AW - BW;
    localparam int QW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int CW = $clog2(WQ_DEPTH + 1);
    localparam int GW = $clog2(BANK_RD + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_RESP} state_t;

    state_t state, state_nxt;

    // Register array and write-queue payload storage
    logic [VLEN-1:0] mem     [NBANK][DEPTH];
    logic [RW-1:0]   wq_row  [NBANK][WQ_DEPTH];
    logic [VLEN-1:0] wq_data [NBANK][WQ_DEPTH];
    logic [QW-1:0]   wq_head [NBANK];
    logic [CW-1:0]   wq_cnt  [NBANK];

    logic [QW-1:0]       wq_head_nxt [NBANK];
    logic [CW-1:0]       wq_cnt_nxt  [NBANK];
    logic [NBANK-1:0]    wq_drain;
    logic [WQ_DEPTH-1:0] wq_live     [NBANK];

    logic [BW-1:0]    wr_bank [WPORT];
    logic [RW-1:0]    wr_row  [WPORT];
    logic [CW-1:0]    wr_ofs  [WPORT];
    logic [QW-1:0]    wr_pos  [WPORT];
    logic [WPORT-1:0] wr_acc;

    // Collector state
    logic [TAG_W-1:0] tag_q;
    logic [RPORT-1:0] op_vld_q;
    logic [RPORT-1:0] pending;
    logic [AW-1:0]    addr_q    [RPORT];
    logic [VLEN-1:0]  data_q    [RPORT];
    logic [BW-1:0]    slot_bank [RPORT];
    logic [RW-1:0]    slot_row  [RPORT];
    logic [RPORT-1:0] hold;
    logic [RPORT-1:0] grant;
    logic [GW-1:0]    port_used [NBANK];
    logic             req_acc;

    // ------------------------------------------------------------------
    // Write side: per-port bank decode, ready and queue slot assignment
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < WPORT; i++) begin
            wr_bank[i] = wr_addr[i*AW +: BW];
            wr_row[i]  = wr_addr[i*AW+BW +: RW];
        end
    end

    // A port sees the free space left after every lower-index valid port
    // aimed at the same bank, whether or not that lower port was accepted.
    always_comb begin
        for (int i = 0; i < WPORT; i++) begin
            wr_ofs[i] = '0;
            for (int j = 0; j < i; j++) begin
                if (wr_vld[j] && (wr_bank[j] == wr_bank[i]))
                    wr_ofs[i] = wr_ofs[i] + CW'(1);
            end
            wr_rdy[i] = (CW'(WQ_DEPTH) - wq_cnt[wr_bank[i]]) > wr_ofs[i];
            wr_pos[i] = QW'((int'(wq_head[wr_bank[i]]) + int'(wq_cnt[wr_bank[i]])
                             + int'(wr_ofs[i])) % WQ_DEPTH);
        end
    end

    assign wr_acc = wr_vld & wr_rdy;

    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            wq_drain[b]   = rstn && (wq_cnt[b] != '0);
            wq_cnt_nxt[b] = wq_cnt[b] - CW'(wq_drain[b]);
            for (int i = 0; i < WPORT; i++) begin
                if (wr_acc[i] && (wr_bank[i] == BW'(b)))
                    wq_cnt_nxt[b] = wq_cnt_nxt[b] + CW'(1);
            end
            wq_head_nxt[b] = wq_drain[b] ? QW'((int'(wq_head[b]) + 1) % WQ_DEPTH)
                                         : wq_head[b];
        end
    end

    // Marks which physical queue slots currently hold a pending write.
    always_comb begin
        int off;
        off = 0;
        for (int b = 0; b < NBANK; b++) begin
            for (int j = 0; j < WQ_DEPTH; j++) begin
                off = j - int'(wq_head[b]);
                if (off < 0)
                    off = off + WQ_DEPTH;
                wq_live[b][j] = off < int'(wq_cnt[b]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int b = 0; b < NBANK; b++) begin
                wq_head[b] <= '0;
                wq_cnt[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                wq_head[b] <= wq_head_nxt[b];
                wq_cnt[b]  <= wq_cnt_nxt[b];
            end
        end
    end

    // NOTE: payload storage and the register array carry no reset; whether an
    // entry means anything is decided by the reset head/count state alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WPORT; i++) begin
            if (wr_acc[i]) begin
                wq_row[wr_bank[i]][wr_pos[i]]  <= wr_row[i];
                wq_data[wr_bank[i]][wr_pos[i]] <= wr_data[i*VLEN +: VLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NBANK; b++) begin
            if (wq_drain[b])
                mem[b][wq_row[b][wq_head[b]]] <= wq_data[b][wq_head[b]];
        end
    end

    always_comb begin
        wq_empty = 1'b1;
        for (int b = 0; b < NBANK; b++) begin
            if (wq_cnt[b] != '0)
                wq_empty = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read side: RAW hold against queued writes and per-bank port grant
    // ------------------------------------------------------------------
    always_comb begin
        for (int s = 0; s < RPORT; s++) begin
            slot_bank[s] = addr_q[s][BW-1:0];
            slot_row[s]  = addr_q[s][AW-1:BW];
        end
    end

    // Lower slot indices claim a bank's read ports first.
    always_comb begin
        hold  = '0;
        grant = '0;
        for (int b = 0; b < NBANK; b++)
            port_used[b] = '0;
        for (int s = 0; s < RPORT; s++) begin
            for (int j = 0; j < WQ_DEPTH; j++) begin
                if (wq_live[slot_bank[s]][j] && (wq_row[slot_bank[s]][j] == slot_row[s]))
                    hold[s] = 1'b1;
            end
            if ((state == ST_COLLECT) && pending[s] && !hold[s]
                && (port_used[slot_bank[s]] < GW'(BANK_RD))) begin
                grant[s] = 1'b1;
                port_used[slot_bank[s]] = port_used[slot_bank[s]] + GW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Collector FSM
    // ------------------------------------------------------------------
    // NOTE: every flop is updated with <= so all of them sample pre-edge
    // values; combinational blocks use = and read their own results in order.
    always_ff @(posedge clk) begin
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        req_rdy   = 1'b0;
        rsp_vld   = 1'b0;
        case (state)
            ST_IDLE: req_rdy = 1'b1;
            ST_COLLECT: begin
                if ((pending & ~grant) == '0)
                    state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_vld = 1'b1;
                if (rsp_rdy) begin
                    req_rdy   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (req_vld && req_rdy)
            state_nxt = (req_op_vld == '0) ? ST_RESP : ST_COLLECT;
    end

    assign req_acc = req_vld & req_rdy;

    // Data is cleared on accept so slots that are never granted read as 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag_q    <= '0;
            op_vld_q <= '0;
            pending  <= '0;
            for (int s = 0; s < RPORT; s++) begin
                addr_q[s] <= '0;
                data_q[s] <= '0;
            end
        end else if (req_acc) begin
            tag_q    <= req_tag;
            op_vld_q <= req_op_vld;
            pending  <= req_op_vld;
            for (int s = 0; s < RPORT; s++) begin
                addr_q[s] <= req_op_addr[s*AW +: AW];
                data_q[s] <= '0;
            end
        end else begin
            pending <= pending & ~grant;
            for (int s = 0; s < RPORT; s++) begin
                if (grant[s])
                    data_q[s] <= mem[slot_bank[s]][slot_row[s]];
            end
        end
    end

    assign rsp_tag    = tag_q;
    assign rsp_op_vld = op_vld_q;

    always_comb begin
        for (int s = 0; s < RPORT; s++)
            rsp_data[s*VLEN +: VLEN] = data_q[s];
    end

endmodule

// File: tb/tb_vrf_banked_collector.sv
// Self-checking bench for vrf_banked_collector: table-driven read requests with
// a response scoreboard, plus hand-written RAW, WAW, queue-full and reset cases.
module tb_vrf_banked_collector;
    logic           clk = 1'b0;
    logic           rstn;
    logic           req_vld;
    logic           req_rdy;
    logic [5:0]     req_tag;
    logic [3:0]     req_op_vld;
    logic [23:0]    req_op_addr;
    logic           rsp_vld;
    logic           rsp_rdy;
    logic [5:0]     rsp_tag;
    logic [3:0]     rsp_op_vld;
    logic [511:0]   rsp_data;
    logic [1:0]     wr_vld;
    logic [1:0]     wr_rdy;
    logic [11:0]    wr_addr;
    logic [255:0]   wr_data;
    logic           wq_empty;

    typedef struct {
        logic [5:0]       tag;
        logic [3:0]       op;
        logic [3:0][5:0]  addr;
        int               lat;
    } vec_t;

    typedef struct {
        logic [5:0]   tag;
        logic [3:0]   op;
        logic [511:0] data;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    vec_t         vecs[8];
    logic [127:0] ref_mem[64];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    vrf_banked_collector #(
        .NBANK(4), .DEPTH(16), .VLEN(128), .RPORT(4), .BANK_RD(2),
        .WPORT(2), .WQ_DEPTH(4), .TAG_W(6)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_tag(req_tag),
        .req_op_vld(req_op_vld), .req_op_addr(req_op_addr),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_tag(rsp_tag),
        .rsp_op_vld(rsp_op_vld), .rsp_data(rsp_data),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
        .wq_empty(wq_empty)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [127:0] val(input int i);
        return (128'(i) << 64) | 128'(160 + i);
    endfunction

    function automatic logic [511:0] exp_data(input logic [3:0] op, input logic [3:0][5:0] a);
        logic [511:0] r;
        r = '0;
        for (int s = 0; s < 4; s++)
            if (op[s]) r[s*128 +: 128] = ref_mem[a[s]];
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input vec_t v, input string name);
        req_vld     = 1'b1;
        req_tag     = v.tag;
        req_op_vld  = v.op;
        req_op_addr = v.addr;
        #1;
        check({name, "_req_rdy"}, 512'(req_rdy), 512'(1'b1));
        sb.push_back('{tag: v.tag, op: v.op, data: exp_data(v.op, v.addr), lat: v.lat});
        tick();
        req_vld = 1'b0;
        wr_vld  = '0;
    endtask

    task automatic await_rsp(input string name);
        int   n;
        exp_t e;
        n = 1;
        while (!rsp_vld && n < 20) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        check({name, "_lat"}, 512'(n), 512'(e.lat));
        check({name, "_tag"}, 512'(rsp_tag), 512'(e.tag));
        check({name, "_op_vld"}, 512'(rsp_op_vld), 512'(e.op));
        check({name, "_data"}, rsp_data, e.data);
    endtask

    task automatic run_req(input vec_t v, input string name);
        issue_req(v, name);
        await_rsp(name);
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!wq_empty && n < 50) begin
            tick();
            n++;
        end
        check(name, 512'(wq_empty), 512'(1'b1));
    endtask

    initial begin
        vec_t         v;
        logic [5:0]   a0, a1;
        logic [127:0] d0, d1;
        logic [1:0]   exp_rdy;

        rstn = 1'b0; req_vld = 1'b0; req_tag = '0; req_op_vld = '0; req_op_addr = '0;
        rsp_rdy = 1'b0; wr_vld = '0; wr_addr = '0; wr_data = '0;

        vecs[0] = '{tag: 6'd5,  op: 4'b1111, addr: {6'd3,  6'd2,  6'd1,  6'd0},  lat: 2};
        vecs[1] = '{tag: 6'd9,  op: 4'b1111, addr: {6'd12, 6'd8,  6'd4,  6'd0},  lat: 3};
        vecs[2] = '{tag: 6'd3,  op: 4'b0101, addr: {6'd0,  6'd11, 6'd0,  6'd7},  lat: 2};
        vecs[3] = '{tag: 6'd63, op: 4'b0000, addr: {6'd0,  6'd0,  6'd0,  6'd0},  lat: 1};
        vecs[4] = '{tag: 6'd12, op: 4'b1111, addr: {6'd5,  6'd5,  6'd5,  6'd5},  lat: 3};
        vecs[5] = '{tag: 6'd33, op: 4'b1110, addr: {6'd17, 6'd13, 6'd9,  6'd0},  lat: 3};
        vecs[6] = '{tag: 6'd1,  op: 4'b1000, addr: {6'd63, 6'd0,  6'd0,  6'd0},  lat: 2};
        vecs[7] = '{tag: 6'd20, op: 4'b1111, addr: {6'd15, 6'd10, 6'd5,  6'd0},  lat: 2};

        repeat (3) tick();
        rstn = 1'b1;
        #1;
        check("rst_req_rdy", 512'(req_rdy), 512'(1'b1));
        check("rst_rsp_vld", 512'(rsp_vld), 512'(1'b0));
        check("rst_rsp_tag", 512'(rsp_tag), 512'(0));
        check("rst_rsp_op_vld", 512'(rsp_op_vld), 512'(0));
        check("rst_rsp_data", rsp_data, 512'(0));
        check("rst_wr_rdy", 512'(wr_rdy), 512'(2'b11));
        check("rst_wq_empty", 512'(wq_empty), 512'(1'b1));
        tick();

        // Preload every register: even/odd pairs always hit different banks.
        for (int k = 0; k < 32; k++) begin
            wr_vld  = 2'b11;
            wr_addr = {6'(2*k+1), 6'(2*k)};
            wr_data = {val(2*k+1), val(2*k)};
            ref_mem[2*k]   = val(2*k);
            ref_mem[2*k+1] = val(2*k+1);
            #1;
            check("preload_wr_rdy", 512'(wr_rdy), 512'(2'b11));
            tick();
        end
        wr_vld = '0;
        wait_empty("preload_drain");

        for (int k = 0; k < 8; k++)
            run_req(vecs[k], $sformatf("vec%0d", k));

        // RAW: write r6 and read r6 accepted in the same cycle.
        wr_vld  = 2'b01;
        wr_addr = {6'd0, 6'd6};
        wr_data = {128'd0, 128'h55};
        ref_mem[6] = 128'h55;
        #1;
        check("raw_wr_rdy", 512'(wr_rdy), 512'(2'b11));
        v = '{tag: 6'd21, op: 4'b0001, addr: {6'd0, 6'd0, 6'd0, 6'd6}, lat: 3};
        run_req(v, "raw");

        // WAW: both ports write r5 in one cycle; port 1 must win.
        wr_vld  = 2'b11;
        wr_addr = {6'd5, 6'd5};
        wr_data = {128'h2, 128'h1};
        #1;
        check("waw_wr_rdy", 512'(wr_rdy), 512'(2'b11));
        ref_mem[5] = 128'h1;
        ref_mem[5] = 128'h2;
        tick();
        wr_vld = '0;
        wait_empty("waw_drain");
        v = '{tag: 6'd2, op: 4'b0001, addr: {6'd0, 6'd0, 6'd0, 6'd5}, lat: 2};
        run_req(v, "waw");

        // Queue full: both ports hammer bank 1 for four cycles.
        for (int c = 0; c < 4; c++) begin
            a0 = 6'(1 + 8*c);
            a1 = 6'(5 + 8*c);
            d0 = 128'h1000 + 128'(a0);
            d1 = 128'h1000 + 128'(a1);
            exp_rdy = (c < 2) ? 2'b11 : 2'b01;
            wr_vld  = 2'b11;
            wr_addr = {a1, a0};
            wr_data = {d1, d0};
            #1;
            check($sformatf("qfull_wr_rdy_c%0d", c), 512'(wr_rdy), 512'(exp_rdy));
            check($sformatf("qfull_empty_c%0d", c), 512'(wq_empty), 512'(c == 0));
            if (exp_rdy[0]) ref_mem[a0] = d0;
            if (exp_rdy[1]) ref_mem[a1] = d1;
            tick();
        end
        wr_vld = '0;
        for (int c = 4; c < 8; c++) begin
            check($sformatf("qfull_empty_c%0d", c), 512'(wq_empty), 512'(c == 7));
            tick();
        end
        v = '{tag: 6'd40, op: 4'b1111, addr: {6'd13, 6'd9, 6'd5, 6'd1}, lat: 3};
        run_req(v, "qfull_rd0");
        v = '{tag: 6'd41, op: 4'b1111, addr: {6'd29, 6'd25, 6'd21, 6'd17}, lat: 3};
        run_req(v, "qfull_rd1");

        // Backpressure: response held three cycles with a new request waiting.
        v = '{tag: 6'd7, op: 4'b1111, addr: {6'd12, 6'd8, 6'd4, 6'd0}, lat: 3};
        issue_req(v, "bp");
        await_rsp("bp");
        req_vld     = 1'b1;
        req_tag     = 6'd44;
        req_op_vld  = 4'b1111;
        req_op_addr = {6'd13, 6'd9, 6'd5, 6'd1};
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_rsp_vld", 512'(rsp_vld), 512'(1'b1));
            check("bp_req_rdy", 512'(req_rdy), 512'(1'b0));
            check("bp_rsp_tag", 512'(rsp_tag), 512'(6'd7));
            check("bp_rsp_data", rsp_data, exp_data(4'b1111, {6'd12, 6'd8, 6'd4, 6'd0}));
            tick();
        end
        rsp_rdy = 1'b1;
        wr_vld  = 2'b01;
        wr_addr = {6'd0, 6'd2};
        wr_data = {128'd0, 128'hDEAD};
        #1;
        check("bp_accept_req_rdy", 512'(req_rdy), 512'(1'b1));
        check("bp_accept_wr_rdy", 512'(wr_rdy), 512'(2'b11));
        tick();
        rsp_rdy = 1'b0;
        req_vld = 1'b0;
        wr_vld  = '0;
        #1;
        check("mid_collect_rsp_vld", 512'(rsp_vld), 512'(1'b0));
        check("mid_collect_wq_empty", 512'(wq_empty), 512'(1'b0));

        // Synchronous reset mid-COLLECT with one write still queued.
        rstn = 1'b0;
        tick();
        check("rst2_rsp_vld", 512'(rsp_vld), 512'(1'b0));
        check("rst2_req_rdy", 512'(req_rdy), 512'(1'b1));
        check("rst2_wq_empty", 512'(wq_empty), 512'(1'b1));
        check("rst2_rsp_tag", 512'(rsp_tag), 512'(0));
        check("rst2_rsp_data", rsp_data, 512'(0));
        rstn = 1'b1;
        tick();
        v = '{tag: 6'd50, op: 4'b0001, addr: {6'd0, 6'd0, 6'd0, 6'd2}, lat: 2};
        run_req(v, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
